// File: rtl/deserializer_multilane_fsm_pkg.sv
// Shared definitions for the deserializer and its serializer successor.
package deserializer_multilane_fsm_pkg;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_FULL    = 1'b1
  } state_t;

  // Counter width for n states; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/deserializer_multilane_fsm_lane_shift_reg.sv
// Lane-wide shift register; q_next exposes the word as it will look once the
// current beat is shifted in, so a completed word can be captured in one cycle.
module lane_shift_reg #(
  parameter int DATA_WIDTH = 24,
  parameter int LANE_WIDTH = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic                  clear,
  input  logic [LANE_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] q_next
);

  logic [DATA_WIDTH-1:0] base;

  // clear drops stale beats so the incoming beat starts a fresh word.
  always_comb begin
    base = clear ? '0 : q;
    if (MSB_FIRST)
      q_next = (base << LANE_WIDTH) | DATA_WIDTH'(din);
    else
      q_next = (base >> LANE_WIDTH) | (DATA_WIDTH'(din) << (DATA_WIDTH - LANE_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (shift_en)
      q <= q_next;
  end

endmodule

// File: rtl/deserializer_multilane_fsm.sv
// Multilane deserializer with round-robin channel tags, frame resync and
// valid/ready on both sides.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_COLLECT | output register empty, collecting beats
// S_FULL    | word held in output register, next word may be collected
module deserializer_multilane_fsm
  import deserializer_multilane_fsm_pkg::*;
#(
  parameter int  DATA_WIDTH   = 24,
  parameter int  LANE_WIDTH   = 1,
  parameter int  NUM_CHANNELS = 1,
  parameter bit  MSB_FIRST    = 1'b1,
  localparam int CH_W         = clog2_min1(NUM_CHANNELS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [LANE_WIDTH-1:0] iv_din,
  input  logic                  i_din_valid,
  input  logic                  i_sof,
  input  logic                  i_ready,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] ov_dout,
  output logic [CH_W-1:0]       ov_channel,
  output logic                  o_dout_valid,
  output logic                  o_frame_err
);

  localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int BW    = clog2_min1(BEATS);

  state_t                state;
  logic [BW-1:0]         beat_cnt;
  logic [CH_W-1:0]       ch_cnt;
  logic                  frame_err_q;

  logic                  last_slot;
  logic                  accept;
  logic                  sof_acc;
  logic                  complete;
  logic                  drain;
  logic [BW-1:0]         beat_idx;
  logic [CH_W-1:0]       ch_base;
  logic [CH_W-1:0]       ch_after;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] word_next;

  // Backpressure only when the completing beat could not be parked anywhere.
  assign last_slot = (beat_cnt == BW'(BEATS - 1));
  assign o_ready   = i_en & ~((state == S_FULL) & last_slot & ~i_ready);
  assign accept    = i_din_valid & o_ready;
  assign sof_acc   = accept & i_sof;
  assign beat_idx  = i_sof ? '0 : beat_cnt;
  assign complete  = accept & (beat_idx == BW'(BEATS - 1));
  assign drain     = o_dout_valid & i_ready & i_en;

  assign ch_base   = sof_acc ? '0 : ch_cnt;
  assign ch_after  = (ch_base == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_base + 1'b1;

  assign o_frame_err = frame_err_q & i_en;

  lane_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_WIDTH (LANE_WIDTH),
    .MSB_FIRST  (MSB_FIRST)
  ) u_shift (
    .clk      (i_clk),
    .rst      (i_rst),
    .shift_en (accept),
    .clear    (sof_acc),
    .din      (iv_din),
    .q        (shift_q),
    .q_next   (word_next)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_COLLECT;
      beat_cnt     <= '0;
      ch_cnt       <= '0;
      ov_dout      <= '0;
      ov_channel   <= '0;
      o_dout_valid <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= sof_acc & (beat_cnt != '0);
      if (i_en) begin
        if (accept)
          beat_cnt <= complete ? '0 : beat_idx + 1'b1;
        if (complete)
          ch_cnt <= ch_after;
        else if (sof_acc)
          ch_cnt <= '0;
        // Completion in S_FULL is only possible when draining, so loading wins.
        case (state)
          S_COLLECT: begin
            if (complete) begin
              ov_dout      <= word_next;
              ov_channel   <= ch_base;
              o_dout_valid <= 1'b1;
              state        <= S_FULL;
            end
          end
          S_FULL: begin
            if (complete) begin
              ov_dout      <= word_next;
              ov_channel   <= ch_base;
              o_dout_valid <= 1'b1;
            end else if (drain) begin
              o_dout_valid <= 1'b0;
              state        <= S_COLLECT;
            end
          end
          default: state <= S_COLLECT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deserializer_multilane_fsm.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus;
// expected words are queued as issued and popped by a monitor on each transfer.
module tb_deserializer_multilane_fsm;

  typedef struct {
    logic [23:0] d;
    logic [1:0]  ch;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b1;
  logic [3:0]  iv_din = '0;
  logic        i_din_valid = 1'b0;
  logic        i_sof = 1'b0;
  logic        i_ready = 1'b1;

  logic        o_ready_m, o_dout_valid_m, o_frame_err_m;
  logic [23:0] ov_dout_m;
  logic [1:0]  ov_channel_m;
  logic        o_ready_l, o_dout_valid_l, o_frame_err_l;
  logic [23:0] ov_dout_l;
  logic [1:0]  ov_channel_l;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ferr_m = 0;
  int ferr_l = 0;
  exp_t q_m[$];
  exp_t q_l[$];
  int   xfer_cyc[$];

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cycle <= cycle + 1;

  deserializer_multilane_fsm #(
    .DATA_WIDTH(24), .LANE_WIDTH(4), .NUM_CHANNELS(3), .MSB_FIRST(1'b1)
  ) dut_m (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .i_sof(i_sof), .i_ready(i_ready),
    .o_ready(o_ready_m), .ov_dout(ov_dout_m), .ov_channel(ov_channel_m),
    .o_dout_valid(o_dout_valid_m), .o_frame_err(o_frame_err_m)
  );

  deserializer_multilane_fsm #(
    .DATA_WIDTH(24), .LANE_WIDTH(4), .NUM_CHANNELS(3), .MSB_FIRST(1'b0)
  ) dut_l (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
    .i_din_valid(i_din_valid), .i_sof(i_sof), .i_ready(i_ready),
    .o_ready(o_ready_l), .ov_dout(ov_dout_l), .ov_channel(ov_channel_l),
    .o_dout_valid(o_dout_valid_l), .o_frame_err(o_frame_err_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] rev_nib(input logic [23:0] x);
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = x[4*(5-i) +: 4];
    return r;
  endfunction

  task automatic push(input logic [23:0] w, input logic [1:0] ch);
    q_m.push_back('{d: w, ch: ch});
    q_l.push_back('{d: rev_nib(w), ch: ch});
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_frame_err_m) ferr_m++;
    if (o_frame_err_l) ferr_l++;
    if (!i_rst && i_en && i_ready) begin
      if (o_dout_valid_m) begin
        xfer_cyc.push_back(cycle);
        if (q_m.size() == 0) check("msb_unexpected_word", {8'h0, ov_dout_m}, 32'hFFFFFFFF);
        else begin
          e = q_m.pop_front();
          check("msb_word", {8'h0, ov_dout_m}, {8'h0, e.d});
          check("msb_channel", {30'h0, ov_channel_m}, {30'h0, e.ch});
        end
      end
      if (o_dout_valid_l) begin
        if (q_l.size() == 0) check("lsb_unexpected_word", {8'h0, ov_dout_l}, 32'hFFFFFFFF);
        else begin
          e = q_l.pop_front();
          check("lsb_word", {8'h0, ov_dout_l}, {8'h0, e.d});
          check("lsb_channel", {30'h0, ov_channel_l}, {30'h0, e.ch});
        end
      end
    end
  end

  task automatic send_beat(input logic [3:0] d, input logic sof);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    iv_din = d;
    i_sof = sof;
    i_din_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = o_ready_m && i_en;
      @(posedge i_clk);
      n++;
    end
    #1;
    i_din_valid = 1'b0;
    i_sof = 1'b0;
    if (!acc) check("beat_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [23:0] w, input logic sof_first);
    for (int i = 0; i < 6; i++) send_beat(w[23-4*i -: 4], sof_first && (i == 0));
  endtask

  task automatic do_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    idle(2);
    i_rst = 1'b0;

    // Basic assembly and latency
    do_reset();
    push(24'hABCDEF, 2'd0);
    send_word(24'hABCDEF, 1'b0);
    @(negedge i_clk);
    check("t1_valid_after_last_beat", {31'h0, o_dout_valid_m}, 32'd1);
    check("t1_dout_msb", {8'h0, ov_dout_m}, 32'hABCDEF);
    check("t1_dout_lsb", {8'h0, ov_dout_l}, 32'hFEDCBA);
    @(negedge i_clk);
    check("t1_valid_one_cycle", {31'h0, o_dout_valid_m}, 32'd0);
    idle(2);

    // Channel rotation, back-to-back
    do_reset();
    xfer_cyc.delete();
    push(24'h111111, 2'd0);
    push(24'h222222, 2'd1);
    push(24'h333333, 2'd2);
    push(24'h444444, 2'd0);
    send_word(24'h111111, 1'b0);
    send_word(24'h222222, 1'b0);
    send_word(24'h333333, 1'b0);
    send_word(24'h444444, 1'b0);
    idle(3);
    check("t2_transfer_count", xfer_cyc.size(), 32'd4);
    for (int i = 1; i < xfer_cyc.size(); i++)
      check("t2_word_spacing", xfer_cyc[i] - xfer_cyc[i-1], 32'd6);

    // Backpressure
    do_reset();
    i_ready = 1'b0;
    push(24'h123456, 2'd0);
    push(24'h789ABC, 2'd1);
    send_word(24'h123456, 1'b0);
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    send_beat(4'h9, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b0);
    iv_din = 4'hC;
    i_din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("t3_backpressure_ready", {31'h0, o_ready_m}, 32'd0);
      check("t3_held_word", {8'h0, ov_dout_m}, 32'h123456);
      check("t3_held_valid", {31'h0, o_dout_valid_m}, 32'd1);
      @(posedge i_clk); #1;
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    check("t3_ready_on_drain", {31'h0, o_ready_m}, 32'd1);
    @(posedge i_clk); #1;
    i_din_valid = 1'b0;
    @(negedge i_clk);
    check("t3_next_valid", {31'h0, o_dout_valid_m}, 32'd1);
    check("t3_next_word", {8'h0, ov_dout_m}, 32'h789ABC);
    idle(2);

    // Frame resync; channel counter is 2 here, so sof must force channel 0
    push(24'h987654, 2'd0);
    send_beat(4'h1, 1'b0);
    send_beat(4'h2, 1'b0);
    send_beat(4'h3, 1'b0);
    send_word(24'h987654, 1'b1);
    idle(3);
    check("t4_frame_err_pulses_msb", ferr_m, 32'd1);
    check("t4_frame_err_pulses_lsb", ferr_l, 32'd1);
    push(24'h123456, 2'd0);
    push(24'hABCDEF, 2'd1);
    send_word(24'h123456, 1'b1);
    send_word(24'hABCDEF, 1'b0);
    idle(3);
    check("t4_no_err_on_aligned_sof", ferr_m, 32'd1);

    // Reset mid-word
    send_beat(4'hE, 1'b0);
    send_beat(4'hE, 1'b0);
    do_reset();
    @(negedge i_clk);
    check("t5_rst_valid", {31'h0, o_dout_valid_m}, 32'd0);
    check("t5_rst_dout", {8'h0, ov_dout_m}, 32'd0);
    check("t5_rst_channel", {30'h0, ov_channel_m}, 32'd0);
    check("t5_rst_frame_err", {31'h0, o_frame_err_m}, 32'd0);
    check("t5_rst_dout_lsb", {8'h0, ov_dout_l}, 32'd0);
    @(posedge i_clk); #1;
    push(24'h012345, 2'd0);
    send_word(24'h012345, 1'b0);
    idle(2);

    // Enable gap mid-word
    push(24'h6789AB, 2'd1);
    send_beat(4'h6, 1'b0);
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    iv_din = 4'h9;
    i_din_valid = 1'b1;
    i_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("t6_ready_when_disabled", {31'h0, o_ready_m}, 32'd0);
      @(posedge i_clk); #1;
    end
    i_en = 1'b1;
    send_beat(4'h9, 1'b0);
    send_beat(4'hA, 1'b0);
    send_beat(4'hB, 1'b0);
    idle(3);

    check("final_queue_msb_empty", q_m.size(), 32'd0);
    check("final_queue_lsb_empty", q_l.size(), 32'd0);
    check("final_frame_err_total", ferr_m, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/deserializer_multilane_fsm.md
Name: deserializer_multilane_fsm

Overview:
Parametrised next-generation deserializer for the serial FIR datapath. It accepts a LANE_WIDTH-bit serial stream and assembles DATA_WIDTH-bit words, selectable MSB-first or LSB-first. Each word is tagged with a round-robin channel index so one FIR pipeline can serve several time-multiplexed channels. It sits between the chip-level serial input and the FIR filter, with valid/ready on both sides, and adds frame resynchronisation and error reporting.

Parameters:
DATA_WIDTH, 24, output word width; must be an integer multiple of LANE_WIDTH
LANE_WIDTH, 1, bits accepted per input beat (1 reproduces the single-bit deserializer)
NUM_CHANNELS, 1, channels interleaved word-by-word; >=1
MSB_FIRST, 1, 1 = first beat lands in the word MSBs; 0 = first beat lands in the LSBs
CH_W, derived clog2(NUM_CHANNELS) (min 1), channel tag width (localparam)
BEATS, derived DATA_WIDTH/LANE_WIDTH (localparam)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_en  in  1  global enable; low freezes all state
iv_din  in  LANE_WIDTH  serial beat data
i_din_valid  in  1  beat valid
i_sof  in  1  start-of-frame, qualified by i_din_valid; marks this beat as beat 0 of channel 0
i_ready  in  1  downstream ready
o_ready  out  1  block can accept a beat this cycle
ov_dout  out  DATA_WIDTH  assembled word
ov_channel  out  CH_W  channel tag of ov_dout
o_dout_valid  out  1  ov_dout/ov_channel valid
o_frame_err  out  1  one-cycle pulse: i_sof accepted while a partial word was pending

Behaviour:
- Reset (i_rst high at a clock edge, any state): beat counter=0, channel counter=0, shift register=0, ov_dout=0, ov_channel=0, o_dout_valid=0, o_frame_err=0, state=S_COLLECT. A partial word is discarded.
- Beat accepted when i_en & i_din_valid & o_ready. Word transferred out when o_dout_valid & i_ready & i_en.
- i_en low: no accept, no transfer, o_ready=0, all registers hold; o_frame_err forced 0.
- Assembly: MSB_FIRST=1 shifts left, new beat into the LSBs; MSB_FIRST=0 shifts right, new beat into the MSBs. After BEATS beats, the first beat occupies the MSBs or LSBs respectively.
- States:
  S_COLLECT: output register empty. On the accepted beat with beat counter==BEATS-1: load ov_dout with the completed word, ov_channel with the channel counter, set o_dout_valid, reset the beat counter, advance the channel counter, go to S_FULL.
  S_FULL: word held stable while i_ready is low. Further beats for the next word are accepted while the beat counter < BEATS-1.
    - Completing beat with the output draining in the same cycle: load the new word, remain S_FULL.
    - Completing beat without draining: o_ready=0 (backpressure), so the beat is not accepted.
    - Drain with no completing beat: clear o_dout_valid, go to S_COLLECT.
- o_ready = i_en & ~(state==S_FULL & beat counter==BEATS-1 & ~i_ready).
- Latency: the word is valid on the cycle after its final beat is accepted. Sustained throughput is 1 beat/cycle with i_ready held high.
- Channel counter wraps NUM_CHANNELS-1 -> 0. With NUM_CHANNELS=1, ov_channel is constant 0.
- i_sof on an accepted beat:
  - beat counter forced so this beat is beat 0; the channel counter is 0 for this word;
  - any partial word is dropped, and o_frame_err pulses the next cycle if the dropped beat count was nonzero;
  - a word already held in the output register is unaffected.
- i_sof on the completing beat of a 1-beat word (BEATS=1) behaves as a normal completion with channel 0.
- Simultaneous completing beat, output drain and i_sof: the drain happens, then the new word loads with channel 0.

Decomposition:
- Shared package: state encoding (S_COLLECT, S_FULL) and a clog2-with-minimum-1 helper function. The same helper is reused by the planned serializer successor.
- Natural sub-module: lane_shift_reg, the parametrised MSB/LSB-first shift register with load-enable and clear. The FSM, counters and handshake stay in the top module.

Test Plan:
- DATA_WIDTH=24, LANE_WIDTH=4, MSB_FIRST=1, i_ready=1; beats A,B,C,D,E,F -> ov_dout=0xABCDEF, o_dout_valid high for 1 cycle, one cycle after beat F.
- Same stimulus with MSB_FIRST=0 -> ov_dout=0xFEDCBA.
- NUM_CHANNELS=3, 4 back-to-back words 0x111111, 0x222222, 0x333333, 0x444444 -> ov_channel 0,1,2,0. No idle cycles between o_dout_valid pulses beyond the required 6-beat spacing.
- i_ready held low after word 0x123456 -> word held stable; 5 more beats accepted; o_ready=0 on the 6th beat. Raise i_ready -> 0x123456 transfers, the 6th beat is accepted the same cycle, and the next word is valid the following cycle.
- Three beats (1,2,3) then a beat 9 with i_sof=1, followed by 8,7,6,5,4 -> o_frame_err pulses once; the output word is 0x987654 with ov_channel=0.
- i_rst pulsed after 2 beats, then 6 beats 0..5 -> ov_dout=0x012345 with channel 0; all outputs are 0 on the cycle after reset. i_en low for 3 cycles mid-word -> result identical to the uninterrupted stream.
